// File: rtl/alu_seq_divider.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): one restoring step per cycle through the shared ALU.
// Optional feature macro: DIV_EARLY_OUT_EN (returns q=0, r=a at once when |a| < |b|).

package alu_seq_divider_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

module alu_seq_divider
    import alu_seq_divider_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output aluop_t          alu_op,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_carry
);

    localparam logic [XLEN-1:0] ZERO_W   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_W   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        cond_neg = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [1:0]       op_r;
    logic [XLEN-1:0]  a_r, b_r;
    logic [XLEN-1:0]  rem_r, quo_r;
    logic [CNT_W-1:0] cnt_r;
    logic             neg_q_r, neg_r_r;
    logic             req_ready_r, resp_valid_r;
    logic [XLEN-1:0]  resp_data_r, alu_in1_r, alu_in2_r;

    logic             signed_op_s, accept_s, div_zero_s, overflow_s, early_s;
    logic             take_s, last_iter_s;
    logic [XLEN-1:0]  abs_a_s, abs_b_s, rs_s, rem_step_s, quo_step_s;

    assign signed_op_s = ~op_r[0];
    assign accept_s    = req_valid & req_ready_r;
    assign abs_a_s     = cond_neg(a_r, signed_op_s & a_r[XLEN-1]);
    assign abs_b_s     = cond_neg(b_r, signed_op_s & b_r[XLEN-1]);
    assign div_zero_s  = (b_r == ZERO_W);
    assign overflow_s  = signed_op_s & (a_r == MIN_NEG) & (b_r == ONES_W);

`ifdef DIV_EARLY_OUT_EN
    assign early_s = (abs_a_s < abs_b_s);
`else
    assign early_s = 1'b0;
`endif

    // rem[31] set means the shifted partial remainder is a 33-bit value, so the subtract must succeed
    assign rs_s        = {rem_r[XLEN-2:0], quo_r[XLEN-1]};
    assign take_s      = alu_carry | rem_r[XLEN-1];
    assign rem_step_s  = take_s ? alu_out : rs_s;
    assign quo_step_s  = {quo_r[XLEN-2:0], take_s};
    assign last_iter_s = (cnt_r == {CNT_W{1'b1}});

    // Next-state logic for the divide sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_nxt_s = S_PREP;
                else          state_nxt_s = S_IDLE;
            end
            S_PREP: begin
                // special cases skip iteration but still pass through FIX (with negation disabled)
                if (div_zero_s || overflow_s || early_s) state_nxt_s = S_FIX;
                else                                     state_nxt_s = S_ITER;
            end
            S_ITER: begin
                if (last_iter_s) state_nxt_s = S_FIX;
                else             state_nxt_s = S_ITER;
            end
            S_FIX: state_nxt_s = S_DONE;
            S_DONE: begin
                if (resp_ready) state_nxt_s = S_IDLE;
                else            state_nxt_s = S_DONE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register, datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r      <= S_IDLE;
            op_r         <= 2'b00;
            a_r          <= ZERO_W;
            b_r          <= ZERO_W;
            rem_r        <= ZERO_W;
            quo_r        <= ZERO_W;
            cnt_r        <= {CNT_W{1'b0}};
            neg_q_r      <= 1'b0;
            neg_r_r      <= 1'b0;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= ZERO_W;
            alu_in1_r    <= ZERO_W;
            alu_in2_r    <= ZERO_W;
        end else begin
            state_r      <= state_nxt_s;
            req_ready_r  <= (state_nxt_s == S_IDLE);
            resp_valid_r <= (state_nxt_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r <= req_op;
                        a_r  <= req_a;
                        b_r  <= req_b;
                    end
                end
                S_PREP: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (div_zero_s) begin
                        quo_r   <= ONES_W;
                        rem_r   <= a_r;
                        neg_q_r <= 1'b0;
                        neg_r_r <= 1'b0;
                    end else if (overflow_s) begin
                        quo_r   <= MIN_NEG;
                        rem_r   <= ZERO_W;
                        neg_q_r <= 1'b0;
                        neg_r_r <= 1'b0;
                    end else if (early_s) begin
                        quo_r   <= ZERO_W;
                        rem_r   <= a_r;
                        neg_q_r <= 1'b0;
                        neg_r_r <= 1'b0;
                    end else begin
                        quo_r     <= abs_a_s;
                        rem_r     <= ZERO_W;
                        neg_q_r   <= signed_op_s & (a_r[XLEN-1] ^ b_r[XLEN-1]);
                        neg_r_r   <= signed_op_s & a_r[XLEN-1];
                        // ALU operands are registered, so the first shifted remainder is prepared here
                        alu_in1_r <= {{(XLEN-1){1'b0}}, abs_a_s[XLEN-1]};
                        alu_in2_r <= abs_b_s;
                    end
                end
                S_ITER: begin
                    rem_r <= rem_step_s;
                    quo_r <= quo_step_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (last_iter_s) begin
                        alu_in1_r <= ZERO_W;
                        alu_in2_r <= ZERO_W;
                    end else begin
                        alu_in1_r <= {rem_step_s[XLEN-2:0], quo_step_s[XLEN-1]};
                    end
                end
                S_FIX: begin
                    if (op_r[1]) resp_data_r <= cond_neg(rem_r, neg_r_r);
                    else         resp_data_r <= cond_neg(quo_r, neg_q_r);
                end
                S_DONE: begin
                    resp_data_r <= resp_data_r;
                end
                default: begin
                    resp_data_r <= resp_data_r;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign alu_op     = ALU_SUB;
    assign alu_in1    = alu_in1_r;
    assign alu_in2    = alu_in2_r;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench for alu_seq_divider: behavioural ALU, directed cases plus random operands
// checked against a plain-arithmetic RV32M reference.

module tb_alu_seq_divider;
    import alu_seq_divider_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    aluop_t      alu_op;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        alu_carry;

    int checks = 0;
    int errors = 0;

    alu_seq_divider #(.XLEN(32), .CNT_W(5)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_carry(alu_carry)
    );

    always #5 CLK = ~CLK;

    // shared ALU, subtract only; carry=1 means no borrow
    always_comb begin
        if (alu_op == ALU_SUB) begin
            alu_out   = alu_in1 - alu_in2;
            alu_carry = (alu_in1 >= alu_in2);
        end else begin
            alu_out   = 32'h0;
            alu_carry = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else if (!op[0]) begin
            q = 32'(sa / sb); r = 32'(sa % sb);
        end else begin
            q = a / b; r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    // edges from the accept edge until resp_valid is first seen: DONE in cycle N+3 or N+35
    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub;
        ua = (!op[0] && a[31]) ? 32'd0 - a : a;
        ub = (!op[0] && b[31]) ? 32'd0 - b : b;
        if (b == 32'd0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (ua < ub) return 2;
`else
        if (ua < ub) return 34;
`endif
        return 34;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge CLK); #1;
            w++;
        end
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        int lat;
        logic [31:0] exp;
        exp = ref_result(op, a, b);
        issue(op, a, b, tag);
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
        end while (!resp_valid && lat < 60);
        check({tag, "_lat"}, 32'(lat), 32'(ref_latency(op, a, b)));
        check({tag, "_data"}, resp_data, exp);
        check({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            check({tag, "_hold_v"}, {31'd0, resp_valid}, 32'd1);
            check({tag, "_hold_d"}, resp_data, exp);
        end
        resp_ready = 1'b1;
        @(posedge CLK); #1;
        resp_ready = 1'b0;
        check({tag, "_drop"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int seen;

        nRST = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 32'd0; req_b = 32'd0; resp_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_op", {28'd0, alu_op}, {28'd0, ALU_SUB});
        check("rst_in1", alu_in1, 32'd0);
        check("rst_in2", alu_in2, 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        run_op(2'b01, 32'd100, 32'd7, 0, "divu_100_7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1, "div_m7_2");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
        run_op(2'b01, 32'd5, 32'd0, 0, "divu_by0");
        run_op(2'b11, 32'd5, 32'd0, 0, "remu_by0");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd0, 0, "div_by0_neg");
        run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 5, "remu_take33");
        check("idle_in1", alu_in1, 32'd0);

        // reset in the middle of iteration: the request must vanish
        issue(2'b01, 32'h1234_5678, 32'd3, "rst_mid");
        repeat (11) @(posedge CLK);
        #1;
        nRST = 1'b0;
        @(posedge CLK); #1;
        check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        check("mid_rst_in1", alu_in1, 32'd0);
        check("mid_rst_in2", alu_in2, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge CLK); #1;
            if (resp_valid) seen++;
        end
        check("mid_rst_noresp", 32'(seen), 32'd0);
        run_op(2'b01, 32'd9, 32'd3, 0, "divu_9_3");
        run_op(2'b01, 32'd3, 32'd9, 0, "early_3_9");
        run_op(2'b10, 32'hFFFF_FFFD, 32'd9, 0, "early_rem_neg");

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 20);
                2: rb = $urandom >> $urandom_range(0, 31);
                default: rb = (i % 8 == 7) ? 32'd0 : 32'd0 - 32'($urandom_range(1, 50));
            endcase
            if (i % 5 == 0) ra = ra >> $urandom_range(16, 31);
            run_op(rop, ra, rb, $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
